// File: rtl/cache_pkg.sv
// Shared types and widths for the victim write-back buffer.
// Line geometry lives here so the entry struct and the address builder agree
// with the port widths of every module that imports this package.
package cache_pkg;

    localparam int WORD_WID = 64;
    localparam int IDX_WID  = 10;
    localparam int TAG_WID  = 19;
    localparam int ADDR_WID = 32;
    localparam int OFF_WID  = $clog2(WORD_WID / 8);

    // One buffered victim line: enough to rebuild its address and write it back.
    typedef struct packed {
        logic [TAG_WID-1:0]  tag;
        logic [IDX_WID-1:0]  idx;
        logic [WORD_WID-1:0] data;
    } wb_entry_t;

    // Memory-side handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } wb_state_e;

    // Line-aligned byte address: {tag, idx, zero byte offset}.
    function automatic logic [ADDR_WID-1:0] build_addr(input logic [TAG_WID-1:0] tag,
                                                       input logic [IDX_WID-1:0] idx);
        return {tag, idx, {OFF_WID{1'b0}}};
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Victim line storage: circular buffer with occupancy count and, when
// VICTIM_WB_FORWARD_EN is defined, a parallel tag/index match used to forward
// buffered data. Without the macro the forwarding outputs are tied to zero.
module wb_fifo
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  wb_entry_t            push_entry,
    input  logic [IDX_WID-1:0]   lookup_idx,
    input  logic [TAG_WID-1:0]   lookup_tag,
    output wb_entry_t            head,
    output logic                 full,
    output logic                 empty,
    output logic                 fwd_hit,
    output logic [WORD_WID-1:0]  fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    // Full comes from the registered count, so a pop never frees a slot for a push in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Entry payload needs no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef VICTIM_WB_FORWARD_EN
    logic [PTR_W-1:0] slot;

    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                (mem[slot].tag == lookup_tag) &&
                (mem[slot].idx == lookup_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem[slot].data;
            end
        end
    end
`else
    logic unused_lookup;

    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
    assign unused_lookup = ^{lookup_idx, lookup_tag};
`endif

endmodule

// File: rtl/victim_writeback_buffer.sv
// Victim write-back buffer: captures dirty evicted lines, drops clean ones and
// drains them to memory over a req/ack handshake with a one-cycle gap between
// writes. Optional forwarding of buffered data is enabled by VICTIM_WB_FORWARD_EN.
module victim_writeback_buffer
    import cache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 evict_valid_i,
    input  logic                 evict_dirty_i,
    input  logic [IDX_WID-1:0]   evict_idx_i,
    input  logic [TAG_WID-1:0]   evict_tag_i,
    input  logic [WORD_WID-1:0]  evict_data_i,
    output logic                 full_o,
    output logic                 mem_req_o,
    output logic [ADDR_WID-1:0]  mem_addr_o,
    output logic [WORD_WID-1:0]  mem_data_o,
    input  logic                 mem_ack_i,
    input  logic [IDX_WID-1:0]   lookup_idx_i,
    input  logic [TAG_WID-1:0]   lookup_tag_i,
    output logic                 fwd_hit_o,
    output logic [WORD_WID-1:0]  fwd_data_o
);

    wb_state_e  state;
    wb_entry_t  push_entry;
    wb_entry_t  head;
    logic       push;
    logic       pop;
    logic       empty;

    // Clean victims never enter the buffer; the FIFO itself refuses pushes when full.
    assign push       = evict_valid_i & evict_dirty_i;
    assign pop        = (state == REQ) & mem_ack_i;
    assign push_entry = '{tag: evict_tag_i, idx: evict_idx_i, data: evict_data_i};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .lookup_idx (lookup_idx_i),
        .lookup_tag (lookup_tag_i),
        .head       (head),
        .full       (full_o),
        .empty      (empty),
        .fwd_hit    (fwd_hit_o),
        .fwd_data   (fwd_data_o)
    );

    // Memory-side sequencer: latch head into the request registers, hold until ack, then idle one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        mem_addr_o <= build_addr(head.tag, head.idx);
                        mem_data_o <= head.data;
                        mem_req_o  <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Directed testbench for victim_writeback_buffer. Forwarding expectations
// follow VICTIM_WB_FORWARD_EN so the same bench covers both builds.
module tb_victim_writeback_buffer;

    logic        clk;
    logic        rstN;
    logic        evictValid;
    logic        evictDirty;
    logic [9:0]  evictIdx;
    logic [18:0] evictTag;
    logic [63:0] evictData;
    logic        full;
    logic        memReq;
    logic [31:0] memAddr;
    logic [63:0] memData;
    logic        memAck;
    logic [9:0]  lookupIdx;
    logic [18:0] lookupTag;
    logic        fwdHit;
    logic [63:0] fwdData;

    int checks = 0;
    int passed = 0;

`ifdef VICTIM_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    victim_writeback_buffer dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .evict_valid_i (evictValid),
        .evict_dirty_i (evictDirty),
        .evict_idx_i   (evictIdx),
        .evict_tag_i   (evictTag),
        .evict_data_i  (evictData),
        .full_o        (full),
        .mem_req_o     (memReq),
        .mem_addr_o    (memAddr),
        .mem_data_o    (memData),
        .mem_ack_i     (memAck),
        .lookup_idx_i  (lookupIdx),
        .lookup_tag_i  (lookupTag),
        .fwd_hit_o     (fwdHit),
        .fwd_data_o    (fwdData)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected line address built independently from tag and index.
    function automatic logic [31:0] expAddr(input logic [18:0] tag, input logic [9:0] idx);
        return {tag, idx, 3'b000};
    endfunction

    // Advance one clock and settle 1 unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the eviction interface.
    task automatic applyStimulus(input logic v, input logic d, input logic [9:0] idx,
                                 input logic [18:0] tag, input logic [63:0] data);
        evictValid = v;
        evictDirty = d;
        evictIdx   = idx;
        evictTag   = tag;
        evictData  = data;
    endtask

    // One comparison: counts it and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Wait (bounded) for a request, check its payload, acknowledge it, confirm the gap.
    task automatic drainOne(input string tag, input logic [18:0] etag, input logic [9:0] eidx,
                            input logic [63:0] edata);
        int n = 0;
        while (!memReq && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_req"}, {63'd0, memReq}, 64'd1);
        checkOutput({tag, "_addr"}, {32'd0, memAddr}, {32'd0, expAddr(etag, eidx)});
        checkOutput({tag, "_data"}, memData, edata);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        checkOutput({tag, "_gap"}, {63'd0, memReq}, 64'd0);
    endtask

    // Linear directed sequence.
    initial begin
        rstN = 1'b0;
        memAck = 1'b0;
        lookupIdx = '0;
        lookupTag = '0;
        applyStimulus(1'b0, 1'b0, 10'd0, 19'd0, 64'd0);
        tick();
        tick();
        checkOutput("rst_full", {63'd0, full}, 64'd0);
        checkOutput("rst_req", {63'd0, memReq}, 64'd0);
        checkOutput("rst_addr", {32'd0, memAddr}, 64'd0);
        checkOutput("rst_data", memData, 64'd0);
        checkOutput("rst_fwd", {63'd0, fwdHit}, 64'd0);
        rstN = 1'b1;
        tick();

        $display("[TB] single dirty push");
        applyStimulus(1'b1, 1'b1, 10'd5, 19'h1, 64'hAA);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 19'd0, 64'd0);
        checkOutput("lat_req_low", {63'd0, memReq}, 64'd0);
        tick();
        checkOutput("lat_req_high", {63'd0, memReq}, 64'd1);
        checkOutput("first_addr", {32'd0, memAddr}, 64'h2028);
        checkOutput("first_data", memData, 64'hAA);
        lookupIdx = 10'd5;
        lookupTag = 19'h1;
        #1;
        checkOutput("fwd_head_hit", {63'd0, fwdHit}, {63'd0, FWD});
        checkOutput("fwd_head_data", fwdData, FWD ? 64'hAA : 64'd0);
        tick();
        tick();
        checkOutput("hold_req", {63'd0, memReq}, 64'd1);
        checkOutput("hold_addr", {32'd0, memAddr}, 64'h2028);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        checkOutput("gap_req", {63'd0, memReq}, 64'd0);
        tick();
        tick();
        checkOutput("idle_req", {63'd0, memReq}, 64'd0);
        checkOutput("idle_fwd", {63'd0, fwdHit}, 64'd0);

        $display("[TB] clean victim dropped");
        applyStimulus(1'b1, 1'b0, 10'd7, 19'h2, 64'h77);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 19'd0, 64'd0);
        repeat (5) tick();
        checkOutput("clean_req", {63'd0, memReq}, 64'd0);
        checkOutput("clean_full", {63'd0, full}, 64'd0);

        $display("[TB] fill to full without acks");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 10'(k + 1), 19'(16 + k), 64'(256 + k));
            tick();
        end
        checkOutput("fill_full", {63'd0, full}, 64'd1);
        checkOutput("fill_req", {63'd0, memReq}, 64'd1);
        checkOutput("fill_head_addr", {32'd0, memAddr}, {32'd0, expAddr(19'h10, 10'd1)});
        checkOutput("fill_head_data", memData, 64'h100);
        applyStimulus(1'b1, 1'b1, 10'd5, 19'h14, 64'h104);
        tick();
        checkOutput("fifth_full", {63'd0, full}, 64'd1);

        $display("[TB] push and ack in the same full cycle");
        applyStimulus(1'b1, 1'b1, 10'd6, 19'h15, 64'h105);
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        checkOutput("ackpush_full", {63'd0, full}, 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 19'd0, 64'd0);
        checkOutput("ackpush_refull", {63'd0, full}, 64'd1);
        drainOne("drain1", 19'h11, 10'd2, 64'h101);
        drainOne("drain2", 19'h12, 10'd3, 64'h102);
        drainOne("drain3", 19'h13, 10'd4, 64'h103);
        drainOne("drain4", 19'h15, 10'd6, 64'h105);
        repeat (8) tick();
        checkOutput("drained_req", {63'd0, memReq}, 64'd0);
        checkOutput("drained_full", {63'd0, full}, 64'd0);

        $display("[TB] reset during request");
        applyStimulus(1'b1, 1'b1, 10'd3, 19'h7, 64'h3C);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 19'd0, 64'd0);
        tick();
        checkOutput("prerst_req", {63'd0, memReq}, 64'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_req", {63'd0, memReq}, 64'd0);
        checkOutput("async_addr", {32'd0, memAddr}, 64'd0);
        checkOutput("async_data", memData, 64'd0);
        #3;
        rstN = 1'b1;
        repeat (6) tick();
        checkOutput("postrst_req", {63'd0, memReq}, 64'd0);

        $display("[TB] duplicate entries and forwarding");
        applyStimulus(1'b1, 1'b1, 10'd9, 19'h33, 64'h11);
        tick();
        applyStimulus(1'b1, 1'b1, 10'd9, 19'h33, 64'h22);
        tick();
        applyStimulus(1'b0, 1'b0, 10'd0, 19'd0, 64'd0);
        lookupIdx = 10'd9;
        lookupTag = 19'h33;
        #1;
        checkOutput("fwd_dup_hit", {63'd0, fwdHit}, {63'd0, FWD});
        checkOutput("fwd_dup_data", fwdData, FWD ? 64'h22 : 64'd0);
        lookupTag = 19'h34;
        #1;
        checkOutput("fwd_miss", {63'd0, fwdHit}, 64'd0);
        drainOne("dup1", 19'h33, 10'd9, 64'h11);
        drainOne("dup2", 19'h33, 10'd9, 64'h22);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
